branch_predict_ctrl: RTL

BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

---
 rtl/branch_predict_ctrl_if.sv | 32 +++
 rtl/branch_predict_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl_if.sv
// Fetch/execute signal bundle for the branch predictor controller.
// The master modport is the pipeline side and the slave modport is the predictor.
interface branch_predict_ctrl_if;
  logic [31:0] fetch_pc;
  logic        fetch_is_branch;
  logic        predict_taken;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_predicted;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output fetch_pc, fetch_is_branch, stall, ex_valid, ex_pc,
           ex_predicted, ex_taken, ex_target,
    input  predict_taken, redirect, redirect_pc, flush,
           branch_count, mispredict_count
  );

  modport slave (
    input  fetch_pc, fetch_is_branch, stall, ex_valid, ex_pc,
           ex_predicted, ex_taken, ex_target,
    output predict_taken, redirect, redirect_pc, flush,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Bimodal predictor built from 2-bit saturating counters.
// On a mispredict it issues a one-cycle redirect and then holds flush for FLUSH_CYCLES cycles.
module branch_predict_ctrl #(
  parameter int ENTRIES      = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  branch_predict_ctrl_if.slave bp
);
  localparam int IDX = $clog2(ENTRIES);
  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t                 r_state;
  logic                   r_redirect;
  logic                   r_flush;
  logic [31:0]            r_redirect_pc;
  logic [2:0]             r_flush_cnt;
  logic [31:0]            r_branch_count;
  logic [31:0]            r_mispredict_count;
  logic [2*ENTRIES-1:0]   r_ctr;
  logic [2*ENTRIES-1:0]   w_ctr_next;

  logic [IDX-1:0] w_fetch_idx;
  logic [IDX-1:0] w_ex_idx;
  logic           w_accept;
  logic           w_mispredict;
  logic           w_unused;

  assign w_fetch_idx  = bp.fetch_pc[IDX+1:2];
  assign w_ex_idx     = bp.ex_pc[IDX+1:2];
  assign w_accept     = bp.ex_valid && !bp.stall && (r_state == IDLE);
  assign w_mispredict = w_accept && (bp.ex_taken != bp.ex_predicted);
  assign w_unused     = &{1'b0, bp.fetch_pc[31:IDX+2], bp.fetch_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  assign bp.predict_taken    = bp.fetch_is_branch && r_ctr[{w_fetch_idx, 1'b1}];
  assign bp.redirect         = r_redirect;
  assign bp.redirect_pc      = r_redirect_pc;
  assign bp.flush            = r_flush;
  assign bp.branch_count     = r_branch_count;
  assign bp.mispredict_count = r_mispredict_count;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
      logic [1:0] w_cur;
      logic [1:0] w_sat;
      assign w_cur = r_ctr[2*gi +: 2];
      assign w_sat = bp.ex_taken ? ((w_cur == 2'b11) ? 2'b11 : w_cur + 2'd1)
                                 : ((w_cur == 2'b00) ? 2'b00 : w_cur - 2'd1);
      assign w_ctr_next[2*gi +: 2] = (w_accept && (w_ex_idx == IDX'(gi))) ? w_sat : w_cur;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr <= {ENTRIES{2'b01}};
    end else begin
      r_ctr <= w_ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_accept)     r_branch_count     <= r_branch_count + 32'd1;
      if (w_mispredict) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  // r_flush_cnt counts flush-high cycles including the one being presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_redirect    <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_flush_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mispredict) begin
            r_state       <= REDIRECT;
            r_redirect    <= 1'b1;
            r_flush       <= 1'b1;
            r_redirect_pc <= bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;
            r_flush_cnt   <= 3'd1;
          end
        end
        REDIRECT: begin
          r_redirect <= 1'b0;
          if (FLUSH_CYCLES > 1) begin
            r_state     <= FLUSH;
            r_flush     <= 1'b1;
            r_flush_cnt <= 3'd2;
          end else begin
            r_state     <= IDLE;
            r_flush     <= 1'b0;
            r_flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (r_flush_cnt >= FC) begin
            r_state     <= IDLE;
            r_flush     <= 1'b0;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + 3'd1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_redirect  <= 1'b0;
          r_flush     <= 1'b0;
          r_flush_cnt <= '0;
        end
      endcase
    end
  end
endmodule
